// File: rtl/pipe_ctrl_pkg.sv
// Shared stall-vector encoding, bit indices and redirect FSM state type for pipe_ctrl.
// One stall bit per pipeline register: bit i held, bit i+1 free means a bubble enters stage i+1.
package pipe_ctrl_pkg;

    localparam int STALL_BITS  = 6;
    localparam int INST_ADDR_W = 32;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [STALL_BITS-1:0] STALL_NONE   = 6'b000000;
    localparam logic [STALL_BITS-1:0] STALL_ALL    = 6'b111111;
    localparam logic [STALL_BITS-1:0] STALL_BY_MEM = 6'b011111;
    localparam logic [STALL_BITS-1:0] STALL_BY_ID  = 6'b000111;
    localparam logic [STALL_BITS-1:0] STALL_BY_IF  = 6'b000011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } pend_state_e;

    // Highest-priority requester wins; a frozen pipeline overrides everything.
    function automatic logic [STALL_BITS-1:0] stall_encode(
        input logic rdy,
        input logic req_mem,
        input logic req_id,
        input logic req_if
    );
        logic [STALL_BITS-1:0] vec;
        vec = STALL_NONE;
        if (!rdy) begin
            vec = STALL_ALL;
        end else if (req_mem) begin
            vec = STALL_BY_MEM;
        end else if (req_id) begin
            vec = STALL_BY_ID;
        end else if (req_if) begin
            vec = STALL_BY_IF;
        end
        return vec;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones instead of wrapping.
// Count is visible the cycle after the qualifying event; clear has priority over enable.
module pipe_ctrl_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall vector, mispredict flush/redirect, and pending redirect held while PC is frozen.
// Stall/flush/redirect are combinational in the request cycle; counters and pending state update on posedge.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_W = STALL_BITS,
    parameter int ADDR_W  = INST_ADDR_W,
    parameter int CNT_W   = INST_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_mem,
    input  logic               ex_mispredict,
    input  logic [ADDR_W-1:0]  ex_target_pc,
    output logic [STALL_W-1:0] stall_sign,
    output logic               flush,
    output logic               pc_redirect,
    output logic [ADDR_W-1:0]  pc_target,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    pend_state_e       state_q;
    logic [ADDR_W-1:0] pend_pc_q;
    logic              pend_valid;

    logic [STALL_BITS-1:0] stall_vec;
    logic                  pc_frozen;
    logic                  ex_held;
    logic                  accept;
    logic                  redirect_now;

    logic [CNT_W-1:0] stall_cnt_raw;
    logic [CNT_W-1:0] flush_cnt_raw;

    assign pend_valid = (state_q == ST_PEND);

    always_comb begin
        stall_vec = STALL_NONE;
        if (rst) begin
            stall_vec = stall_encode(rdy, stallreq_mem, stallreq_id, stallreq_if);
        end
    end

    assign stall_sign = STALL_W'(stall_vec);
    assign pc_frozen  = stall_vec[STALL_PC];
    assign ex_held    = stall_vec[STALL_EX];

    // A mispredict arriving while EX is held is not lost: EX keeps presenting it.
    assign accept = rst && ex_mispredict && !ex_held;

    assign redirect_now = rst && !pc_frozen && (accept || pend_valid);

    always_comb begin
        flush       = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        if (rst) begin
            flush = accept || pend_valid;
            if (redirect_now) begin
                pc_redirect = 1'b1;
                pc_target   = accept ? ex_target_pc : pend_pc_q;
            end
        end
    end

    // A fresh accept while pending replaces the saved target before any release is considered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pend_pc_q <= '0;
        end else if (rdy) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && pc_frozen) begin
                        state_q   <= ST_PEND;
                        pend_pc_q <= ex_target_pc;
                    end
                end
                ST_PEND: begin
                    if (accept && pc_frozen) begin
                        pend_pc_q <= ex_target_pc;
                    end else if (!pc_frozen) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    pipe_ctrl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr_i (!rst),
        .en_i  (rdy && pc_frozen),
        .cnt_o (stall_cnt_raw)
    );

    pipe_ctrl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .clr_i (!rst),
        .en_i  (accept),
        .cnt_o (flush_cnt_raw)
    );

    assign stall_cnt = rst ? stall_cnt_raw : '0;
    assign flush_cnt = rst ? flush_cnt_raw : '0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle-level reference model checked every cycle plus literal checkpoints.
module tb_pipe_ctrl;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst, rdy, sif, sid, smem, mp;
    logic [31:0] tgt;
    logic [5:0]  stall_sign;
    logic        flush, pc_redirect;
    logic [31:0] pc_target;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // reference model state
    bit m_pend = 0;
    int unsigned m_pc = 0;
    int m_sc = 0;
    int m_fc = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.STALL_W(6), .ADDR_W(32), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .stallreq_if   (sif),
        .stallreq_id   (sid),
        .stallreq_mem  (smem),
        .ex_mispredict (mp),
        .ex_target_pc  (tgt),
        .stall_sign    (stall_sign),
        .flush         (flush),
        .pc_redirect   (pc_redirect),
        .pc_target     (pc_target),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // every cycle: outputs from the rules, then advance the model as the clock edge will
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [5:0]  e_stall;
            logic        acc, e_flush, e_redir;
            logic [31:0] e_tgt;
            if (!rst)       e_stall = 6'b000000;
            else if (!rdy)  e_stall = 6'b111111;
            else if (smem)  e_stall = 6'b011111;
            else if (sid)   e_stall = 6'b000111;
            else if (sif)   e_stall = 6'b000011;
            else            e_stall = 6'b000000;
            acc     = rst && mp && !e_stall[3];
            e_flush = rst && (acc || m_pend);
            e_redir = e_flush && !e_stall[0];
            e_tgt   = !e_redir ? 32'h0 : (acc ? tgt : m_pc);
            chk("m_stall",    {58'd0, stall_sign}, {58'd0, e_stall});
            chk("m_flush",    {63'd0, flush}, {63'd0, e_flush});
            chk("m_redirect", {63'd0, pc_redirect}, {63'd0, e_redir});
            chk("m_target",   {32'd0, pc_target}, {32'd0, e_tgt});
            chk("m_stall_cnt", {60'd0, stall_cnt}, rst ? 64'(m_sc) : 64'd0);
            chk("m_flush_cnt", {60'd0, flush_cnt}, rst ? 64'(m_fc) : 64'd0);
            if (!rst) begin
                m_pend = 0; m_pc = 0; m_sc = 0; m_fc = 0;
            end else begin
                if (acc && e_stall[0]) begin
                    m_pend = 1; m_pc = tgt;
                end else if (e_redir) begin
                    m_pend = 0;
                end
                if (rdy && e_stall[0]) m_sc = (m_sc + 1 > MAXC) ? MAXC : m_sc + 1;
                if (acc)               m_fc = (m_fc + 1 > MAXC) ? MAXC : m_fc + 1;
            end
        end
    end

    // apply inputs just after a rising edge, then wait to the sampling point
    task automatic drive(input logic r, input logic rd, input logic i_f, input logic i_d,
                         input logic i_m, input logic m, input logic [31:0] t);
        @(posedge clk); #1;
        rst = r; rdy = rd; sif = i_f; sid = i_d; smem = i_m; mp = m; tgt = t;
        @(negedge clk); #1;
    endtask

    initial begin
        rst = 0; rdy = 1; sif = 0; sid = 0; smem = 0; mp = 0; tgt = 0;
        cmp_en = 1'b1;
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("rst_stall", {58'd0, stall_sign}, 64'h0);
        chk("rst_redirect", {63'd0, pc_redirect}, 64'h0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("idle_stall", {58'd0, stall_sign}, 64'h0);
        chk("idle_cnt", {60'd0, stall_cnt}, 64'h0);

        // 1: mem + id
        drive(1, 1, 0, 1, 1, 0, 0);
        chk("t1_stall", {58'd0, stall_sign}, 64'h1f);
        drive(1, 1, 0, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("t1_free", {58'd0, stall_sign}, 64'h0);
        chk("t1_cnt", {60'd0, stall_cnt}, 64'd2);

        // 2: immediate redirect
        drive(1, 1, 0, 0, 0, 1, 32'h0000_1040);
        chk("t2_flush", {63'd0, flush}, 64'd1);
        chk("t2_redir", {63'd0, pc_redirect}, 64'd1);
        chk("t2_tgt", {32'd0, pc_target}, 64'h1040);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("t2_fcnt", {60'd0, flush_cnt}, 64'd1);

        // 3: mispredict during IF stall becomes pending
        drive(1, 1, 1, 0, 0, 1, 32'h200);
        chk("t3_c1_flush", {63'd0, flush}, 64'd1);
        chk("t3_c1_redir", {63'd0, pc_redirect}, 64'd0);
        drive(1, 1, 1, 0, 0, 0, 0);
        chk("t3_c2_flush", {63'd0, flush}, 64'd1);
        drive(1, 1, 1, 0, 0, 0, 0);
        chk("t3_c3_flush", {63'd0, flush}, 64'd1);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("t3_rel_redir", {63'd0, pc_redirect}, 64'd1);
        chk("t3_rel_tgt", {32'd0, pc_target}, 64'h200);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("t3_done_flush", {63'd0, flush}, 64'd0);
        chk("t3_fcnt", {60'd0, flush_cnt}, 64'd2);
        chk("t3_scnt", {60'd0, stall_cnt}, 64'd5);

        // 4: EX held by MEM, accept only once MEM drops
        drive(1, 1, 0, 0, 1, 1, 32'h400);
        chk("t4_noflush", {63'd0, flush}, 64'd0);
        drive(1, 1, 0, 0, 1, 1, 32'h400);
        drive(1, 1, 0, 0, 0, 1, 32'h400);
        chk("t4_acc_tgt", {32'd0, pc_target}, 64'h400);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("t4_fcnt", {60'd0, flush_cnt}, 64'd3);
        chk("t4_scnt", {60'd0, stall_cnt}, 64'd7);

        // 5: reset drops a pending redirect
        drive(1, 1, 0, 1, 0, 1, 32'h300);
        drive(1, 1, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("t5_rst_flush", {63'd0, flush}, 64'd0);
        chk("t5_rst_cnt", {60'd0, flush_cnt}, 64'd0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("t5_no_redir", {63'd0, pc_redirect}, 64'd0);
        chk("t5_scnt", {60'd0, stall_cnt}, 64'd0);

        // 6: freeze during pending, then release
        drive(1, 1, 0, 1, 0, 1, 32'h500);
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("t6_frz_stall", {58'd0, stall_sign}, 64'h3f);
        chk("t6_frz_redir", {63'd0, pc_redirect}, 64'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("t6_rel_tgt", {32'd0, pc_target}, 64'h500);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("t6_scnt", {60'd0, stall_cnt}, 64'd1);
        chk("t6_fcnt", {60'd0, flush_cnt}, 64'd1);

        // override while pending, and override coinciding with release
        drive(1, 1, 1, 0, 0, 1, 32'h600);
        drive(1, 1, 1, 0, 0, 1, 32'h700);
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("ovr_tgt", {32'd0, pc_target}, 64'h700);
        drive(1, 1, 1, 0, 0, 1, 32'h800);
        drive(1, 1, 0, 0, 0, 1, 32'h900);
        chk("ovr_rel_tgt", {32'd0, pc_target}, 64'h900);

        // saturation
        for (int i = 0; i < 20; i++) drive(1, 1, 1, 0, 0, 0, 0);
        chk("sat_scnt", {60'd0, stall_cnt}, 64'(MAXC));
        drive(1, 1, 1, 0, 0, 0, 0);
        chk("sat_hold", {60'd0, stall_cnt}, 64'(MAXC));
        drive(1, 1, 0, 0, 0, 0, 0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
